// File: rtl/banked_regfile.sv
// banked_regfile: 2**BANKW register banks (R1-R5, SP=R6, PC=R7; R0 reads zero)
// with a bank-return stack for nested trap entry / return.
module banked_regfile #(
  parameter int               WIDTH = 16,
  parameter int               BANKW = 2,
  parameter int               DEPTH = 4,
  parameter int               TRAPW = 4,
  parameter int               STEP  = 2,
  parameter logic [WIDTH-1:0] IVEC  = 16'h0004,
  localparam int              NBANKS = 2 ** BANKW,
  localparam int              DW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ra0,
  input  logic [2:0]       ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             we,
  input  logic [2:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             incr_sp,
  input  logic             decr_sp,
  input  logic             incr_pc,
  input  logic             pc_rewind,
  input  logic             trap_enter,
  input  logic [BANKW-1:0] trap_bank,
  input  logic [TRAPW-1:0] trapnr,
  input  logic             reti,
  output logic [BANKW-1:0] bank,
  output logic [DW-1:0]    depth,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] sp_out,
  output logic             overflow,
  output logic             underflow
);

  localparam int               PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]       A_R1   = 3'd1;
  localparam logic [2:0]       A_SP   = 3'd6;
  localparam logic [2:0]       A_PC   = 3'd7;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Entry 0 of each bank is never written and stays zero.
  logic [WIDTH-1:0] regs_q  [NBANKS][8];
  logic [WIDTH-1:0] regs_d  [NBANKS][8];
  logic [BANKW-1:0] stack_q [DEPTH];
  logic [BANKW-1:0] stack_d [DEPTH];
  logic [BANKW-1:0] bank_q, bank_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full, empty;
  logic             do_trap, do_ovf, do_reti, do_unf;
  logic [DW-1:0]    depth_dec;
  logic [PW-1:0]    push_idx, pop_idx;

  // Classify stack events; trap_enter silently swallows a same-cycle reti.
  always_comb begin
    full      = (depth_q == DW'(DEPTH));
    empty     = (depth_q == '0);
    do_trap   = trap_enter & ~full;
    do_ovf    = trap_enter & full;
    do_reti   = reti & ~trap_enter & ~empty;
    do_unf    = reti & ~trap_enter & empty;
    depth_dec = depth_q - DW'(1);
    push_idx  = depth_q[PW-1:0];
    pop_idx   = depth_dec[PW-1:0];
  end

  // Next-state for bank, depth, stack and the error pulses.
  always_comb begin
    bank_d      = bank_q;
    depth_d     = depth_q;
    stack_d     = stack_q;
    overflow_d  = do_ovf;
    underflow_d = do_unf;
    if (do_trap) begin
      stack_d[push_idx] = bank_q;
      bank_d            = trap_bank;
      depth_d           = depth_q + DW'(1);
    end else if (do_reti) begin
      bank_d  = stack_q[pop_idx];
      depth_d = depth_dec;
    end
  end

  // Register write-back: later assignments carry higher priority.
  always_comb begin
    regs_d = regs_q;
    if (we && wa != 3'd0) begin
      regs_d[bank_q][wa] = wd;
    end
    if (incr_sp) begin
      regs_d[bank_q][A_SP] = regs_q[bank_q][A_SP] + STEP_W;
    end else if (decr_sp) begin
      regs_d[bank_q][A_SP] = regs_q[bank_q][A_SP] - STEP_W;
    end
    if (pc_rewind) begin
      regs_d[bank_q][A_PC] = regs_q[bank_q][A_PC] - STEP_W;
    end else if (incr_pc) begin
      regs_d[bank_q][A_PC] = regs_q[bank_q][A_PC] + STEP_W;
    end
    // The bank being left is rearmed so its next entry starts at its vector.
    if (do_reti) begin
      regs_d[bank_q][A_PC] = (bank_q == '0) ? '0 : IVEC;
    end
    if (do_trap) begin
      regs_d[trap_bank][A_R1] = WIDTH'(trapnr);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int r = 0; r < 8; r++) begin
          regs_q[b][r] <= (r == 7 && b != 0) ? IVEC : '0;
        end
      end
      for (int s = 0; s < DEPTH; s++) begin
        stack_q[s] <= '0;
      end
      bank_q      <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      stack_q     <= stack_d;
      bank_q      <= bank_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Combinational reads of the current bank; no bypass of same-cycle writes.
  always_comb begin
    rd0       = (ra0 == 3'd0) ? '0 : regs_q[bank_q][ra0];
    rd1       = (ra1 == 3'd0) ? '0 : regs_q[bank_q][ra1];
    pc_out    = regs_q[bank_q][A_PC];
    sp_out    = regs_q[bank_q][A_SP];
    bank      = bank_q;
    depth     = depth_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_banked_regfile.sv
// Directed table-driven bench for banked_regfile.
module tb_banked_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ra0, ra1, wa;
  logic [15:0] rd0, rd1, wd, pc_out, sp_out;
  logic        we, incr_sp, decr_sp, incr_pc, pc_rewind, trap_enter, reti;
  logic [1:0]  trap_bank, bank;
  logic [3:0]  trapnr;
  logic [2:0]  depth;
  logic        overflow, underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        isp, dsp, ipc, rew, te;
    logic [1:0]  tb;
    logic [3:0]  tn;
    logic        rt;
    logic [2:0]  ra0, ra1;
    logic [15:0] e_rd0, e_rd1;
    logic [1:0]  e_bank;
    logic [2:0]  e_depth;
    logic [15:0] e_pc, e_sp;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vq[$];

  banked_regfile dut (
    .clk(clk), .reset(reset),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .we(we), .wa(wa), .wd(wd),
    .incr_sp(incr_sp), .decr_sp(decr_sp), .incr_pc(incr_pc), .pc_rewind(pc_rewind),
    .trap_enter(trap_enter), .trap_bank(trap_bank), .trapnr(trapnr), .reti(reti),
    .bank(bank), .depth(depth), .pc_out(pc_out), .sp_out(sp_out),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = 3'd0; wd = 16'h0;
    incr_sp = 1'b0; decr_sp = 1'b0; incr_pc = 1'b0; pc_rewind = 1'b0;
    trap_enter = 1'b0; trap_bank = 2'd0; trapnr = 4'd0; reti = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starting in bank 0 right after reset: read every address of every bank.
  task automatic check_all_banks(input string tag);
    for (int r = 0; r < 8; r++) begin
      ra0 = 3'(r);
      #1;
      chk($sformatf("%s b0 r%0d", tag, r), rd0, 16'h0);
    end
    chk({tag, " b0 bank"}, 16'(bank), 16'h0);
    chk({tag, " b0 depth"}, 16'(depth), 16'h0);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      trap_enter = 1'b1; trap_bank = 2'(b); trapnr = 4'd0;
      @(posedge clk);
      #1;
      idle();
      for (int r = 0; r < 8; r++) begin
        ra0 = 3'(r);
        #1;
        chk($sformatf("%s b%0d r%0d", tag, b, r), rd0, (r == 7) ? 16'h0004 : 16'h0000);
      end
      chk($sformatf("%s b%0d bank", tag, b), 16'(bank), 16'(b));
      chk($sformatf("%s b%0d depth", tag, b), 16'(depth), 16'(b));
    end
  endtask

  task automatic add(input int we_i, input int wa_i, input int wd_i,
                     input int isp, input int dsp, input int ipc, input int rew,
                     input int te, input int tb, input int tn, input int rt,
                     input int a0, input int a1, input int e0, input int e1,
                     input int eb, input int ed, input int epc, input int esp,
                     input int eo, input int eu);
    vec_t v;
    v.we = 1'(we_i); v.wa = 3'(wa_i); v.wd = 16'(wd_i);
    v.isp = 1'(isp); v.dsp = 1'(dsp); v.ipc = 1'(ipc); v.rew = 1'(rew);
    v.te = 1'(te); v.tb = 2'(tb); v.tn = 4'(tn); v.rt = 1'(rt);
    v.ra0 = 3'(a0); v.ra1 = 3'(a1); v.e_rd0 = 16'(e0); v.e_rd1 = 16'(e1);
    v.e_bank = 2'(eb); v.e_depth = 3'(ed); v.e_pc = 16'(epc); v.e_sp = 16'(esp);
    v.e_ovf = 1'(eo); v.e_unf = 1'(eu);
    vq.push_back(v);
  endtask

  // Driver + comparison for each queued vector; one edge per vector.
  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      @(negedge clk);
      we = vq[i].we; wa = vq[i].wa; wd = vq[i].wd;
      incr_sp = vq[i].isp; decr_sp = vq[i].dsp; incr_pc = vq[i].ipc; pc_rewind = vq[i].rew;
      trap_enter = vq[i].te; trap_bank = vq[i].tb; trapnr = vq[i].tn; reti = vq[i].rt;
      ra0 = vq[i].ra0; ra1 = vq[i].ra1;
      @(posedge clk);
      #1;
      chk($sformatf("%s%0d rd0", tag, i), rd0, vq[i].e_rd0);
      chk($sformatf("%s%0d rd1", tag, i), rd1, vq[i].e_rd1);
      chk($sformatf("%s%0d bank", tag, i), 16'(bank), 16'(vq[i].e_bank));
      chk($sformatf("%s%0d depth", tag, i), 16'(depth), 16'(vq[i].e_depth));
      chk($sformatf("%s%0d pc", tag, i), pc_out, vq[i].e_pc);
      chk($sformatf("%s%0d sp", tag, i), sp_out, vq[i].e_sp);
      chk($sformatf("%s%0d ovf", tag, i), 16'(overflow), 16'(vq[i].e_ovf));
      chk($sformatf("%s%0d unf", tag, i), 16'(underflow), 16'(vq[i].e_unf));
      idle();
    end
    vq.delete();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ra0 = 3'd0; ra1 = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_banks("rst");
    apply_reset();

    // Bank 0: write, PC/SP counters, wrap, priorities, R0 write ignored.
    //  we wa wd        isp dsp ipc rew te tb tn rt ra0 ra1 rd0      rd1      b d pc       sp       o u
    add(1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0, 3, 7, 16'hBEEF, 16'h0002, 0, 0, 16'h0002, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0, 3, 7, 16'hBEEF, 16'h0004, 0, 0, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0, 3, 7, 16'hBEEF, 16'h0006, 0, 0, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        1, 0, 0, 0, 0, 0, 0, 0, 6, 7, 16'h0002, 16'h0006, 0, 0, 16'h0006, 16'h0002, 0, 0);
    add(0, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0, 6, 7, 16'h0000, 16'h0006, 0, 0, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0, 6, 7, 16'hFFFE, 16'h0006, 0, 0, 16'h0006, 16'hFFFE, 0, 0);
    add(0, 0, 0,        0, 1, 0, 0, 0, 0, 0, 0, 6, 7, 16'hFFFC, 16'h0006, 0, 0, 16'h0006, 16'hFFFC, 0, 0);
    add(1, 6, 16'h5555, 1, 1, 0, 0, 0, 0, 0, 0, 6, 7, 16'hFFFE, 16'h0006, 0, 0, 16'h0006, 16'hFFFE, 0, 0);
    add(1, 6, 16'h5555, 0, 1, 0, 0, 0, 0, 0, 0, 6, 7, 16'hFFFC, 16'h0006, 0, 0, 16'h0006, 16'hFFFC, 0, 0);
    add(1, 6, 16'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 6, 7, 16'h5555, 16'h0006, 0, 0, 16'h0006, 16'h5555, 0, 0);
    add(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h0000, 16'hBEEF, 0, 0, 16'h0006, 16'h5555, 0, 0);
    add(1, 7, 16'h0100, 0, 0, 1, 0, 0, 0, 0, 0, 7, 3, 16'h0008, 16'hBEEF, 0, 0, 16'h0008, 16'h5555, 0, 0);
    add(1, 7, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 16'h0100, 16'hBEEF, 0, 0, 16'h0100, 16'h5555, 0, 0);
    run_table("a");

    apply_reset();
    ra0 = 3'd3; ra1 = 3'd7;
    #1;
    chk("post-rst r3", rd0, 16'h0000);
    chk("post-rst pc", pc_out, 16'h0000);
    chk("post-rst sp", sp_out, 16'h0000);

    // Trap entry/return, nesting, overflow/underflow, PC priorities.
    //  we wa wd        isp dsp ipc rew te tb tn rt ra0 ra1 rd0      rd1      b d pc       sp       o u
    add(1, 1, 16'h1234, 0, 0, 1, 0, 1, 1, 5, 0, 1, 7, 16'h0005, 16'h0004, 1, 1, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 16'h1234, 16'h0002, 0, 0, 16'h0002, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 1, 1, 0, 1, 7, 16'h0001, 16'h0004, 1, 1, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 2, 2, 0, 1, 7, 16'h0002, 16'h0004, 2, 2, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0, 1, 7, 16'h0002, 16'h0006, 2, 2, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 3, 3, 0, 1, 7, 16'h0003, 16'h0004, 3, 3, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 1, 0, 0, 0, 0, 0, 1, 7, 16'h0003, 16'h0006, 3, 3, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 3, 7, 0, 1, 7, 16'h0007, 16'h0006, 3, 4, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 1, 9, 0, 1, 7, 16'h0007, 16'h0006, 3, 4, 16'h0006, 16'h0000, 1, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h0007, 16'h0006, 3, 4, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 16'h0007, 16'h0004, 3, 3, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 16'h0002, 16'h0006, 2, 2, 16'h0006, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 16'h0001, 16'h0004, 1, 1, 16'h0004, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 16'h1234, 16'h0002, 0, 0, 16'h0002, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 16'h1234, 16'h0002, 0, 0, 16'h0002, 16'h0000, 0, 1);
    add(0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h1234, 16'h0002, 0, 0, 16'h0002, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 2, 2, 1, 1, 7, 16'h0002, 16'h0004, 2, 1, 16'h0004, 16'h0000, 0, 0);
    add(1, 7, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h0002, 16'h0010, 2, 1, 16'h0010, 16'h0000, 0, 0);
    add(1, 7, 16'h0100, 0, 0, 1, 1, 0, 0, 0, 0, 1, 7, 16'h0002, 16'h000E, 2, 1, 16'h000E, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 1, 0, 0, 0, 0, 1, 7, 16'h0002, 16'h000C, 2, 1, 16'h000C, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 1, 0, 0, 0, 1, 1, 7, 16'h1234, 16'h0002, 0, 0, 16'h0002, 16'h0000, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 1, 2, 6, 0, 1, 7, 16'h0006, 16'h0004, 2, 1, 16'h0004, 16'h0000, 0, 0);
    add(1, 6, 16'h5555, 1, 1, 0, 0, 0, 0, 0, 0, 6, 7, 16'h0002, 16'h0004, 2, 1, 16'h0004, 16'h0002, 0, 0);
    add(1, 1, 16'hAAAA, 0, 0, 0, 0, 1, 2, 6, 0, 1, 7, 16'h0006, 16'h0004, 2, 2, 16'h0004, 16'h0002, 0, 0);
    run_table("b");

    // Asynchronous reset mid-sequence (bank 2, depth 2), checked before any edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async bank", 16'(bank), 16'h0);
    chk("async depth", 16'(depth), 16'h0);
    chk("async pc", pc_out, 16'h0000);
    chk("async sp", sp_out, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all_banks("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
